data_ram_resp: RTL
==================

Name: data_ram_resp

Overview:
Data-memory responder: the far end of the load/store path that the execute→memory pipeline register feeds.
- Accepts word-wide requests (address, byte enables, write data) from the memory-access stage over a req/ack handshake.
- Inserts a configurable number of wait states, then commits writes or returns read data.
- Flags misaligned and out-of-range accesses.
- Sits between the memory-access stage and the on-chip data SRAM array it owns.

Parameters:
- ADDR_WIDTH, 10, word-address bits; array depth = 2^ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 1, extra cycles between request capture and ack; legal range 0..15.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- mem_req_i  input  1  request valid; held by requester until ack is seen
- mem_we_i  input  1  1 = write, 0 = read
- mem_addr_i  input  32  byte address
- mem_sel_i  input  4  byte enables for writes; bit i enables wdata[8i+7:8i]
- mem_wdata_i  input  32  write data
- mem_rdata_o  output  32  read data; valid in the ack cycle, held until the next ack
- mem_ack_o  output  1  one-cycle completion pulse
- mem_err_o  output  1  error flag, asserted only together with mem_ack_o

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All outputs are registered.
- Reset values: mem_rdata_o=0, mem_ack_o=0, mem_err_o=0, FSM=IDLE, wait counter=0.
- Array contents are not reset.
- FSM states: IDLE, WAIT, ACK.
  - IDLE: if mem_req_i=1, capture we/addr/sel/wdata into internal registers and load counter=WAIT_CYCLES. Go to WAIT if WAIT_CYCLES>0, else go directly to access.
  - WAIT: decrement counter each cycle. Inputs are ignored; captured values are used. When counter reaches 1, perform the access at the next edge.
  - Access edge: mem_ack_o rises; a write commits to the array on the same edge; mem_rdata_o loads for a read. State → ACK.
  - ACK: mem_ack_o=1 for exactly this cycle. mem_req_i is ignored here (it is still the old request). State → IDLE and ack returns to 0.
- Latency: request first seen in IDLE in cycle N → mem_ack_o high in cycle N+1+WAIT_CYCLES.
  - Minimum transaction spacing is 2+WAIT_CYCLES cycles; a new request is accepted in the IDLE cycle after ACK.
- Word index = addr[ADDR_WIDTH+1:2].
- Reads return the full 32-bit word. mem_sel_i is ignored on reads; byte/half extraction and sign-extension belong to the memory-access stage.
- Writes update only the bytes with sel=1. sel=4'b0000 is acked with no array change and no error.
- Error conditions (evaluated on captured values):
  - addr[1:0]!=0, or
  - addr[31:ADDR_WIDTH+2]!=0 (out of range).
- On error: mem_err_o=1 in the ack cycle, no write occurs, mem_rdata_o loads 0. Ack timing is unchanged.
- mem_err_o=0 on every successful ack and in all non-ack cycles.
- mem_rdata_o is unchanged by writes and between acks.
- Reset mid-operation: rst in any state returns the FSM to IDLE next cycle.
  - Any pending write is dropped (array unchanged) and no ack is issued for the aborted request.
  - A request asserted during a reset cycle is not captured; it is first sampled in the first cycle with rst=0.
- mem_req_i dropping during WAIT is a protocol violation; the responder still completes and acks the captured request.
- Counter width: 4 bits.

Test Plan:
- WAIT_CYCLES=1: write 0xDEADBEEF to 0x10 with sel=4'hF, req first seen in cycle N → ack in N+2, err=0. Then read 0x10 → ack 2 cycles after capture with rdata=0xDEADBEEF.
- Byte enables: write 0x000000AA to 0x10 with sel=4'b0001, then write 0x55000000 with sel=4'b1000 → read 0x10 returns 0x55ADBEAA. A write with sel=0 leaves it unchanged.
- Misaligned and out-of-range: read 0x13 → ack+err, rdata=0. Write 0x12 → ack+err, word 0x10 unchanged. With ADDR_WIDTH=10, read 0x1000 → ack+err.
- Reset mid-WAIT (WAIT_CYCLES=3): issue write 0x12345678 to 0x20, assert rst for 1 cycle during WAIT → no ack. A following read of 0x20 returns the prior value.
- WAIT_CYCLES=0, back-to-back reads of 0x10 and 0x14 with req held continuously:
  - ack in N+1 and N+3;
  - ack never high on two consecutive cycles;
  - rdata holds the first value through cycle N+2.
- Input change during WAIT (WAIT_CYCLES=2): change addr and wdata after capture → access uses the captured values only.

Source files
------------

// File: rtl/data_ram_resp.sv
// Data-memory responder: owns the data SRAM array and serves word-wide load/store
// requests from the memory-access stage with a fixed number of wait states.
module data_ram_resp #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ack_o,
  output logic        mem_err_o
);

  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  localparam bit          DIRECT    = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  sel_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        ack_q;
  logic        err_q;

  logic [31:0] mem_q [DEPTH];

  // Access-edge view of the transaction: live inputs when there are no wait
  // states (capture and access share one edge), captured registers otherwise.
  logic                  access_now;
  logic                  acc_we;
  logic [31:0]           acc_addr;
  logic [3:0]            acc_sel;
  logic [31:0]           acc_wdata;
  logic                  acc_err;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic                  commit;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    access_now = 1'b0;
    acc_we     = we_q;
    acc_addr   = addr_q;
    acc_sel    = sel_q;
    acc_wdata  = wdata_q;
    if (DIRECT && (state_q == S_IDLE) && mem_req_i) begin
      access_now = 1'b1;
      acc_we     = mem_we_i;
      acc_addr   = mem_addr_i;
      acc_sel    = mem_sel_i;
      acc_wdata  = mem_wdata_i;
    end else if ((state_q == S_WAIT) && (cnt_q == 4'd1)) begin
      access_now = 1'b1;
    end
  end

  assign acc_err = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (ADDR_WIDTH + 2)) != 32'd0);
  assign acc_idx = acc_addr[ADDR_WIDTH+1:2];
  assign commit  = access_now && acc_we && !acc_err && !rst;

  // NOTE: the array is deliberately left out of reset; clearing thousands of
  // words would prevent SRAM mapping, and software never relies on contents.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_sel[b]) begin
          mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      sel_q   <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;

      // A faulting access returns zero data whether it was a load or a store.
      if (access_now) begin
        ack_q <= 1'b1;
        err_q <= acc_err;
        if (acc_err) begin
          rdata_q <= 32'd0;
        end else if (!acc_we) begin
          rdata_q <= mem_q[acc_idx];
        end
      end

      case (state_q)
        S_IDLE: begin
          if (mem_req_i) begin
            we_q    <= mem_we_i;
            addr_q  <= mem_addr_i;
            sel_q   <= mem_sel_i;
            wdata_q <= mem_wdata_i;
            cnt_q   <= WAIT_INIT;
            state_q <= DIRECT ? S_ACK : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= S_ACK;
          end
        end
        S_ACK: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_rdata_o = rdata_q;
  assign mem_ack_o   = ack_q;
  assign mem_err_o   = err_q;

endmodule
